// File: rtl/video_timing_if.sv
// Raster timing bundle driven by video_timing_gen toward the pixel source and
// the blue-channel TMDS encoder control inputs.
interface video_timing_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          de;
   logic          hsync;
   logic          vsync;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          frame_start;
   logic          line_end;

   modport master (output de, hsync, vsync, x, y, frame_start, line_end);
   modport slave  (input  de, hsync, vsync, x, y, frame_start, line_end);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered
// de/hsync/vsync, pixel coordinates and frame/line strobes.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   video_timing_if.master  vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);

   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
   localparam logic          HP     = (H_POL != 0);
   localparam logic          VP     = (V_POL != 0);

   logic [XW-1:0] h_cnt_r;
   logic [YW-1:0] v_cnt_r;
   logic [XW-1:0] h_nxt_s;
   logic [YW-1:0] v_nxt_s;
   logic          h_last_s;
   logic          v_last_s;
   logic          h_act_s;
   logic          v_act_s;
   logic          hs_on_s;
   logic          vs_on_s;

   // Region decode of the current counter position (int compare avoids wrap at full-width bounds)
   always_comb begin
      h_last_s = (h_cnt_r == H_LAST);
      v_last_s = (v_cnt_r == V_LAST);
      h_act_s  = (int'(h_cnt_r) < H_ACTIVE);
      v_act_s  = (int'(v_cnt_r) < V_ACTIVE);
      hs_on_s  = (int'(h_cnt_r) >= HS_START) && (int'(h_cnt_r) < HS_END);
      vs_on_s  = (int'(v_cnt_r) >= VS_START) && (int'(v_cnt_r) < VS_END);
   end

   // Next raster position with line and frame wrap
   always_comb begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
      if (h_last_s) begin
         h_nxt_s = {XW{1'b0}};
         if (v_last_s) begin
            v_nxt_s = {YW{1'b0}};
         end else begin
            v_nxt_s = v_cnt_r + YW'(1);
         end
      end else begin
         h_nxt_s = h_cnt_r + XW'(1);
      end
   end

   // Counters advance and outputs register the pre-edge decode on enabled edges
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_r         <= {XW{1'b0}};
         v_cnt_r         <= {YW{1'b0}};
         vid.de          <= 1'b0;
         vid.hsync       <= ~HP;
         vid.vsync       <= ~VP;
         vid.x           <= {XW{1'b0}};
         vid.y           <= {YW{1'b0}};
         vid.frame_start <= 1'b0;
         vid.line_end    <= 1'b0;
      end else if (en) begin
         h_cnt_r         <= h_nxt_s;
         v_cnt_r         <= v_nxt_s;
         vid.de          <= h_act_s && v_act_s;
         vid.hsync       <= hs_on_s ? HP : ~HP;
         vid.vsync       <= vs_on_s ? VP : ~VP;
         vid.x           <= h_cnt_r;
         vid.y           <= v_cnt_r;
         vid.frame_start <= (h_cnt_r == {XW{1'b0}}) && (v_cnt_r == {YW{1'b0}});
         vid.line_end    <= h_last_s;
      end
   end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing controller that sequences the TMDS encoder channels. It runs horizontal and vertical pixel counters and drives de, plus hsync and vsync; hsync and vsync feed c0 and c1 of the blue-channel encoder. It also supplies pixel coordinates and frame/line strobes to the pixel source. It sits in the rgb2dvi path, upstream of the three tmds_encoder instances, in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
Derived values (localparam, not overridable):
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
- XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL)

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-high
en  input  1  pixel clock enable; counters and outputs advance only when high
de  output  1  data enable (active video)
hsync  output  1  horizontal sync, polarity per H_POL
vsync  output  1  vertical sync, polarity per V_POL
x  output  XW  horizontal position of current output cycle
y  output  YW  vertical position of current output cycle
frame_start  output  1  one-cycle pulse at position (0,0)
line_end  output  1  one-cycle pulse at h = H_TOTAL-1

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Internal counters: h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
  - On a clk edge with en=1, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Region ordering per axis: active, front porch, sync, back porch.
  - Horizontal active: h_cnt < H_ACTIVE.
  - hsync asserted: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Vertical active: v_cnt < V_ACTIVE.
  - vsync asserted: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line (all h_cnt).
- Decodes: de = horizontal active AND vertical active. frame_start = (h_cnt==0 && v_cnt==0). line_end = (h_cnt==H_TOTAL-1).
- All outputs are registered from the current counter state. On an edge with en=1, outputs take the decode of the pre-edge counters, and the counters advance on the same edge. Latency is one cycle from counter to output.
- x and y equal the registered h_cnt and v_cnt in every cycle, including blanking. They are only meaningful while de=1.
- en=0: counters and all outputs hold. A pulse output (frame_start, line_end) stays high for as many cycles as en is low. Consumers qualify it with en.
- Reset (rst=1 on edge; overrides en):
  - h_cnt=0, v_cnt=0.
  - de=0, x=0, y=0, frame_start=0, line_end=0.
  - hsync=~H_POL, vsync=~V_POL (inactive levels).
- First edge with rst=0, en=1: outputs show (0,0): de=1, frame_start=1, x=0, y=0. Counters move to (1,0).
- Reset mid-frame: it abandons the frame immediately. The next frame restarts from (0,0) as above. No partial sync pulse is extended.
- Timing sequence is exact: one frame is H_TOTAL*V_TOTAL enabled cycles, and exactly one frame_start occurs per frame.

Test Plan:
Use reduced parameters H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, H_POL=0, V_POL=1, giving H_TOTAL=8 and V_TOTAL=6.
1. Reset release:
   - Hold rst 2 cycles, then en=1.
   - During reset: de=0, hsync=1, vsync=0.
   - First cycle after release: de=1, frame_start=1, x=0, y=0.
2. Line timing:
   - de=1 for x=0..3 and 0 for x=4..7.
   - hsync=0 exactly at x=5,6; line_end=1 only at x=7.
   - Line repeats every 8 cycles.
3. Frame timing:
   - de is never 1 on lines y=3..5.
   - vsync=1 for all 8 cycles of y=4 only.
   - frame_start recurs exactly 48 cycles later, with x and y back to 0.
4. Enable gating:
   - Drop en for 3 cycles at x=2, y=1.
   - All outputs frozen at x=2, y=1, de=1; the sequence resumes at x=3.
   - Total frame length is 51 clocks with exactly one frame_start.
5. Mid-frame reset:
   - Assert rst at x=6, y=4 (hsync=0, vsync=1).
   - Next cycle: hsync=1, vsync=0, de=0.
   - After release: frame restarts at (0,0) with frame_start=1.
6. Default 640x480 parameters:
   - Run 2 frames.
   - Count 307200 de cycles per frame, 420000 cycles between frame_start pulses, and 96-cycle hsync pulses.
